// File: rtl/trans_pkg.sv
// Shared definitions for the transition-counter bank: edge-mode encodings,
// measurement FSM states and a constant-function log2 used for sizing checks.
package trans_pkg;

   localparam logic [1:0] MODE_BOTH = 2'b00;
   localparam logic [1:0] MODE_RISE = 2'b01;
   localparam logic [1:0] MODE_FALL = 2'b10;
   localparam logic [1:0] MODE_HOLD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Smallest r such that 2**r >= value; 0 for value <= 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((longint'(1) << result) < longint'(value)) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/trans_cnt_cell.sv
// One monitored channel: previous-sample register, edge detection against the
// selected mode, and a saturating counter with a sticky saturation flag.
module trans_cnt_cell
   import trans_pkg::*;
#(
   parameter int CW = 32
) (
   input  logic          CLK,
   input  logic          CLR,
   input  logic          sig,
   input  logic [1:0]    mode,
   input  logic          count_en,
   input  logic          clear_all,
   input  logic          clear,
   output logic [CW-1:0] cnt,
   output logic          sat
);

   logic prev;
   logic rise;
   logic fall;
   logic hit;

   assign rise = sig & ~prev;
   assign fall = ~sig & prev;
   assign hit  = count_en &
                 ((rise & ((mode == MODE_BOTH) | (mode == MODE_RISE))) |
                  (fall & ((mode == MODE_BOTH) | (mode == MODE_FALL))));

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         prev <= 1'b0;
      end else begin
         prev <= sig;
      end
   end

   // A per-channel clear still lets an edge in the same cycle register as 1.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         cnt <= '0;
         sat <= 1'b0;
      end else if (clear_all) begin
         cnt <= '0;
         sat <= 1'b0;
      end else if (clear) begin
         cnt <= hit ? CW'(1) : '0;
         sat <= 1'b0;
      end else if (hit) begin
         if (&cnt) begin
            sat <= 1'b1;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/trans_cnt_bank.sv
// Bank of NCH transition counters with a measurement-window FSM and a
// registered one-channel-per-cycle read port with optional read-and-clear.
module trans_cnt_bank
   import trans_pkg::*;
#(
   parameter int NCH = 8,
   parameter int CW  = 32,
   parameter int AW  = 3,
   parameter int WIN = 1000
) (
   input  logic           CLK,
   input  logic           CLR,
   input  logic [NCH-1:0] sig,
   input  logic [1:0]     mode,
   input  logic           start,
   input  logic           stop,
   input  logic           rd_req,
   input  logic [AW-1:0]  rd_dir,
   input  logic           rd_clr,
   output logic           rd_valid,
   output logic [CW-1:0]  rd_dato,
   output logic           rd_err,
   output logic [NCH-1:0] sat,
   output logic           busy,
   output logic           done
);

   localparam int WCW = (WIN > 1) ? clog2(WIN) : 1;
   localparam logic [WCW-1:0] WIN_LAST = WCW'((WIN > 0) ? WIN - 1 : 0);

   if (AW < clog2(NCH)) begin : g_aw_check
      $error("trans_cnt_bank: AW too small to address NCH channels");
   end

   state_t         state;
   state_t         state_nxt;
   logic           armed;
   logic           armed_nxt;
   logic [WCW-1:0] win_cnt;
   logic [WCW-1:0] win_nxt;
   logic           count_en;
   logic           in_range;
   logic [CW-1:0]  rd_sel;
   logic [CW-1:0]  cnt_arr [NCH];

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state   <= ST_IDLE;
         armed   <= 1'b0;
         win_cnt <= '0;
      end else begin
         state   <= state_nxt;
         armed   <= armed_nxt;
         win_cnt <= win_nxt;
      end
   end

   // Start from any state reopens the window; it beats a coincident stop.
   always_comb begin
      state_nxt = state;
      armed_nxt = armed;
      win_nxt   = win_cnt;
      if (start) begin
         state_nxt = ST_RUN;
         armed_nxt = 1'b0;
         win_nxt   = '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               state_nxt = ST_IDLE;
            end
            ST_RUN: begin
               armed_nxt = 1'b1;
               if (stop || ((WIN != 0) && (win_cnt == WIN_LAST))) begin
                  state_nxt = ST_DONE;
               end else if (WIN != 0) begin
                  win_nxt = win_cnt + WCW'(1);
               end
            end
            ST_DONE: begin
               state_nxt = ST_DONE;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign busy     = (state == ST_RUN);
   assign done     = (state == ST_DONE);
   assign count_en = (state == ST_RUN) && armed && (mode != MODE_HOLD) && !start;
   assign in_range = (32'(rd_dir) < NCH);

   for (genvar i = 0; i < NCH; i++) begin : g_cell
      trans_cnt_cell #(
         .CW(CW)
      ) u_cell (
         .CLK       (CLK),
         .CLR       (CLR),
         .sig       (sig[i]),
         .mode      (mode),
         .count_en  (count_en),
         .clear_all (start),
         .clear     (rd_req && rd_clr && in_range && (32'(rd_dir) == i)),
         .cnt       (cnt_arr[i]),
         .sat       (sat[i])
      );
   end

   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NCH; i++) begin
         if (32'(rd_dir) == i) begin
            rd_sel = cnt_arr[i];
         end
      end
   end

   // The read captures the counter before this cycle's increment or clear lands.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         rd_dato  <= '0;
      end else begin
         rd_valid <= rd_req;
         rd_err   <= rd_req && !in_range;
         if (rd_req) begin
            rd_dato <= in_range ? rd_sel : '0;
         end
      end
   end

endmodule

// File: tb/tb_trans_cnt_bank.sv
// Self-checking bench: directed window/edge/saturation/read sequences on three
// differently-sized banks, then a randomized run against a rule-level model.
module tb_trans_cnt_bank;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic CLR;

   // Bank A: default-sized, 5000-cycle window
   logic [7:0]  a_sig;
   logic [1:0]  a_mode;
   logic        a_start, a_stop, a_rd_req, a_rd_clr;
   logic [2:0]  a_rd_dir;
   logic        a_rd_valid, a_rd_err, a_busy, a_done;
   logic [31:0] a_rd_dato;
   logic [7:0]  a_sat;

   // Bank B: 4-bit counters, free-running, unused addresses 6 and 7
   logic [5:0]  b_sig;
   logic [1:0]  b_mode;
   logic        b_start, b_stop, b_rd_req, b_rd_clr;
   logic [2:0]  b_rd_dir;
   logic        b_rd_valid, b_rd_err, b_busy, b_done;
   logic [3:0]  b_rd_dato;
   logic [5:0]  b_sat;

   // Bank C: tiny bank for random checking
   localparam int C_NCH  = 3;
   localparam int C_WIN  = 9;
   localparam int C_CMAX = 7;
   logic [2:0]  c_sig;
   logic [1:0]  c_mode;
   logic        c_start, c_stop, c_rd_req, c_rd_clr;
   logic [1:0]  c_rd_dir;
   logic        c_rd_valid, c_rd_err, c_busy, c_done;
   logic [2:0]  c_rd_dato;
   logic [2:0]  c_sat;

   trans_cnt_bank #(.NCH(8), .CW(32), .AW(3), .WIN(5000)) dut_a (
      .CLK(CLK), .CLR(CLR), .sig(a_sig), .mode(a_mode), .start(a_start), .stop(a_stop),
      .rd_req(a_rd_req), .rd_dir(a_rd_dir), .rd_clr(a_rd_clr), .rd_valid(a_rd_valid),
      .rd_dato(a_rd_dato), .rd_err(a_rd_err), .sat(a_sat), .busy(a_busy), .done(a_done)
   );

   trans_cnt_bank #(.NCH(6), .CW(4), .AW(3), .WIN(0)) dut_b (
      .CLK(CLK), .CLR(CLR), .sig(b_sig), .mode(b_mode), .start(b_start), .stop(b_stop),
      .rd_req(b_rd_req), .rd_dir(b_rd_dir), .rd_clr(b_rd_clr), .rd_valid(b_rd_valid),
      .rd_dato(b_rd_dato), .rd_err(b_rd_err), .sat(b_sat), .busy(b_busy), .done(b_done)
   );

   trans_cnt_bank #(.NCH(C_NCH), .CW(3), .AW(2), .WIN(C_WIN)) dut_c (
      .CLK(CLK), .CLR(CLR), .sig(c_sig), .mode(c_mode), .start(c_start), .stop(c_stop),
      .rd_req(c_rd_req), .rd_dir(c_rd_dir), .rd_clr(c_rd_clr), .rd_valid(c_rd_valid),
      .rd_dato(c_rd_dato), .rd_err(c_rd_err), .sat(c_sat), .busy(c_busy), .done(c_done)
   );

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [1:0] mode;
      int         exp_ch0;
   } win_vec_t;

   win_vec_t win_tbl [4];

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic pulse_a_start();
      a_start = 1'b1;
      @(negedge CLK);
      a_start = 1'b0;
   endtask

   task automatic pulse_b_start();
      b_start = 1'b1;
      @(negedge CLK);
      b_start = 1'b0;
   endtask

   task automatic read_a(input int ch, input bit clr, output logic [31:0] val);
      a_rd_req = 1'b1;
      a_rd_dir = 3'(ch);
      a_rd_clr = clr;
      @(negedge CLK);
      a_rd_req = 1'b0;
      a_rd_clr = 1'b0;
      check("a_rd_valid", a_rd_valid, 1);
      val = a_rd_dato;
   endtask

   task automatic read_b(input int ch, input bit clr, output logic [3:0] val, output logic err);
      b_rd_req = 1'b1;
      b_rd_dir = 3'(ch);
      b_rd_clr = clr;
      @(negedge CLK);
      b_rd_req = 1'b0;
      b_rd_clr = 1'b0;
      check("b_rd_valid", b_rd_valid, 1);
      val = b_rd_dato;
      err = b_rd_err;
   endtask

   // Rule-level model of bank C
   bit m_run, m_done, m_first;
   int m_cycles;
   int m_cnt [C_NCH];
   bit m_sat [C_NCH];
   bit m_prev [C_NCH];
   bit e_valid, e_err;
   int e_dato;

   task automatic model_reset();
      m_run = 0; m_done = 0; m_first = 0; m_cycles = 0;
      e_valid = 0; e_err = 0; e_dato = 0;
      for (int i = 0; i < C_NCH; i++) begin
         m_cnt[i] = 0; m_sat[i] = 0; m_prev[i] = 0;
      end
   endtask

   task automatic model_step();
      bit counting, rise, fall, inc;
      e_valid = c_rd_req;
      e_err   = c_rd_req && (int'(c_rd_dir) >= C_NCH);
      if (c_rd_req) e_dato = (int'(c_rd_dir) >= C_NCH) ? 0 : m_cnt[c_rd_dir];
      counting = m_run && !m_first && (c_mode != 2'b11) && !c_start;
      if (c_start) begin
         for (int i = 0; i < C_NCH; i++) begin
            m_cnt[i] = 0; m_sat[i] = 0;
         end
         m_run = 1; m_done = 0; m_cycles = 0; m_first = 1;
      end else begin
         for (int i = 0; i < C_NCH; i++) begin
            rise = c_sig[i] && !m_prev[i];
            fall = !c_sig[i] && m_prev[i];
            inc  = counting && ((rise && (c_mode == 2'b00 || c_mode == 2'b01)) ||
                                (fall && (c_mode == 2'b00 || c_mode == 2'b10)));
            if (c_rd_req && c_rd_clr && int'(c_rd_dir) == i) begin
               m_cnt[i] = inc ? 1 : 0;
               m_sat[i] = 0;
            end else if (inc) begin
               if (m_cnt[i] == C_CMAX) m_sat[i] = 1;
               else m_cnt[i] = m_cnt[i] + 1;
            end
         end
         if (m_run) begin
            if (c_stop || m_cycles == C_WIN - 1) begin
               m_run = 0; m_done = 1;
            end else begin
               m_cycles = m_cycles + 1;
            end
            m_first = 0;
         end
      end
      for (int i = 0; i < C_NCH; i++) m_prev[i] = c_sig[i];
   endtask

   initial begin
      logic [31:0] va;
      logic [3:0]  vb;
      logic        eb;
      logic [2:0]  esat;
      int          n;
      bit          bad;

      win_tbl[0] = '{2'b00, 100};
      win_tbl[1] = '{2'b01, 50};
      win_tbl[2] = '{2'b10, 50};
      win_tbl[3] = '{2'b11, 0};

      a_sig = 8'hFF; a_mode = 2'b00; a_start = 0; a_stop = 0; a_rd_req = 0; a_rd_clr = 0; a_rd_dir = 0;
      b_sig = 0; b_mode = 2'b00; b_start = 0; b_stop = 0; b_rd_req = 0; b_rd_clr = 0; b_rd_dir = 0;
      c_sig = 0; c_mode = 2'b00; c_start = 0; c_stop = 0; c_rd_req = 0; c_rd_clr = 0; c_rd_dir = 0;
      CLR = 1'b0;
      tick(3);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      check("rst_rd_valid", a_rd_valid, 0);
      check("rst_rd_dato", a_rd_dato, 0);
      check("rst_rd_err", a_rd_err, 0);
      check("rst_sat", a_sat, 0);
      CLR = 1'b1;
      tick(1);

      // Constant high inputs after reset must not look like edges
      pulse_a_start();
      tick(10);
      check("t1_busy", a_busy, 1);
      for (int ch = 0; ch < 8; ch++) begin
         read_a(ch, 0, va);
         check("t1_no_false_edge", va, 0);
      end

      for (int v = 0; v < 4; v++) begin
         a_sig = 8'h00;
         a_mode = win_tbl[v].mode;
         tick(1);
         pulse_a_start();
         tick(3);
         for (int k = 0; k < 100; k++) begin
            a_sig[0] = ~a_sig[0];
            tick(20);
         end
         n = 0;
         while (!a_done && n < 4000) begin
            @(negedge CLK);
            n++;
         end
         check("t2_done", a_done, 1);
         check("t2_busy", a_busy, 0);
         check("t2_window_len", 2003 + n, 5000);
         for (int k = 0; k < 4; k++) begin
            a_sig[0] = ~a_sig[0];
            tick(2);
         end
         read_a(0, 0, va);
         check("t2_ch0_count", va, win_tbl[v].exp_ch0);
         for (int ch = 1; ch < 8; ch++) begin
            read_a(ch, 0, va);
            check("t2_other_ch", va, 0);
         end
      end

      // Read-and-clear colliding with an edge on the same channel
      a_sig = 8'h00; a_mode = 2'b00;
      pulse_a_start();
      tick(2);
      for (int k = 0; k < 3; k++) begin
         a_sig[2] = ~a_sig[2];
         tick(2);
      end
      a_sig[2] = ~a_sig[2];
      read_a(2, 1, va);
      check("t5_old_value", va, 3);
      tick(1);
      read_a(2, 0, va);
      check("t5_after_clear", va, 1);

      // Early stop at cycle 10 freezes counts
      pulse_a_start();
      tick(3); a_sig[3] = 1'b1;
      tick(3); a_sig[3] = 1'b0;
      tick(3);
      a_stop = 1'b1; tick(1); a_stop = 1'b0;
      check("t6_stop_done", a_done, 1);
      check("t6_stop_busy", a_busy, 0);
      a_sig[3] = 1'b1; tick(2); a_sig[3] = 1'b0; tick(2);
      read_a(3, 0, va);
      check("t6_frozen", va, 2);

      a_start = 1'b1; a_stop = 1'b1; tick(1); a_start = 1'b0; a_stop = 1'b0;
      check("start_beats_stop_busy", a_busy, 1);
      check("start_beats_stop_done", a_done, 0);
      tick(2); a_sig[3] = 1'b1; tick(2); a_sig[3] = 1'b0; tick(2);
      read_a(3, 0, va);
      check("t6_run_count", va, 2);
      CLR = 1'b0;
      #1;
      check("midrst_busy", a_busy, 0);
      check("midrst_done", a_done, 0);
      check("midrst_rd_valid", a_rd_valid, 0);
      check("midrst_rd_dato", a_rd_dato, 0);
      check("midrst_rd_err", a_rd_err, 0);
      check("midrst_sat", a_sat, 0);
      @(negedge CLK);
      CLR = 1'b1;
      tick(1);
      read_a(3, 0, va);
      check("midrst_cnt", va, 0);
      check("midrst_idle", a_busy, 0);

      // Saturation with 4-bit counters, free-running window
      b_sig = 0; b_mode = 2'b00;
      tick(1);
      pulse_b_start();
      tick(2);
      for (int k = 0; k < 20; k++) begin
         b_sig[1] = ~b_sig[1];
         tick(2);
      end
      read_b(1, 0, vb, eb);
      check("t4_sat_value", vb, 15);
      check("t4_sat_err", eb, 0);
      check("t4_sat_flag", b_sat, 6'b000010);
      check("t4_freerun_busy", b_busy, 1);
      pulse_b_start();
      read_b(1, 0, vb, eb);
      check("t4_restart_value", vb, 0);
      check("t4_restart_sat", b_sat, 0);
      read_b(6, 0, vb, eb);
      check("t6_err_nch", eb, 1);
      check("t6_err_dato", vb, 0);
      read_b(7, 1, vb, eb);
      check("t6_err_top", eb, 1);
      check("t6_err_top_dato", vb, 0);
      for (int k = 0; k < 20; k++) begin
         b_sig[1] = ~b_sig[1];
         tick(2);
      end
      check("t4_resat_flag", b_sat, 6'b000010);
      read_b(1, 1, vb, eb);
      check("t4_rdclr_value", vb, 15);
      check("t4_rdclr_sat", b_sat, 0);
      read_b(1, 0, vb, eb);
      check("t4_rdclr_zero", vb, 0);
      b_stop = 1'b1; tick(1); b_stop = 1'b0;
      check("t4_stop_done", b_done, 1);

      // Random run on bank C
      CLR = 1'b0;
      model_reset();
      tick(1);
      CLR = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         c_start  = ($urandom_range(0, 99) < 3);
         c_stop   = ($urandom_range(0, 99) < 4);
         c_rd_req = ($urandom_range(0, 99) < 40);
         c_rd_clr = ($urandom_range(0, 99) < 30);
         c_rd_dir = 2'($urandom_range(0, 3));
         c_mode   = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
         c_sig    = 3'($urandom_range(0, 7));
         model_step();
         @(negedge CLK);
         for (int i = 0; i < C_NCH; i++) esat[i] = m_sat[i];
         bad = (c_busy !== m_run) || (c_done !== m_done) || (c_rd_valid !== e_valid) ||
               (c_rd_err !== e_err) || (c_sat !== esat) ||
               (e_valid && (c_rd_dato !== 3'(e_dato)));
         vectors++;
         if (bad) begin
            miscompares++;
            $display("[TB] FAIL rand cyc %0d: busy %b/%b done %b/%b valid %b/%b err %b/%b sat %b/%b dato %0d/%0d (got/expected)",
                     cyc, c_busy, m_run, c_done, m_done, c_rd_valid, e_valid, c_rd_err, e_err,
                     c_sat, esat, c_rd_dato, e_dato);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
